stream_dedup_buffer: RTL and testbench

- Streaming successor to the fixed-array duplicate remover (LeetCode 26/80 family).
- Accepts a sorted stream of WIDTH-bit values over a valid/ready handshake.
- Compacts the stream in place into an internal DEPTH-entry buffer, keeping at most MAX_DUP copies of each value.
- Reports the kept count k and exposes the buffer through a registered read port for the downstream consumer.

---
 rtl/stream_dedup_buffer_if.sv | 13 +
 rtl/stream_dedup_buffer.sv | 159 +++++++++++++++
 tb/tb_stream_dedup_buffer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_dedup_buffer_if.sv
// Sorted-stream input handshake for stream_dedup_buffer: valid/ready with data and
// end-of-pass marker.
interface stream_dedup_buffer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  modport master (output in_valid, output in_data, output in_last, input  in_ready);
  modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

// File: rtl/stream_dedup_buffer.sv
// Streaming duplicate remover: compacts a sorted stream into a DEPTH-entry buffer, keeping
// at most MAX_DUP copies per value. Optional order checker under STREAM_DEDUP_SORT_CHECK_EN.
module stream_dedup_buffer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int MAX_DUP = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  stream_dedup_buffer_if.slave       in_if,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] k,
  output logic                       overflow,
  output logic                       sort_err,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]           rd_data
);

  localparam int KW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MAX_DUP < 1) ? 1 : $clog2(MAX_DUP + 1);
  localparam logic [KW-1:0] DEPTH_C   = KW'(DEPTH);
  localparam logic [CW-1:0] MAX_DUP_C = CW'(MAX_DUP);

  if (MAX_DUP < 1) begin : g_bad_max_dup
    $error("stream_dedup_buffer: MAX_DUP must be at least 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stream_dedup_buffer: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     run_cnt_q, run_cnt_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  rd_data_q;
  logic [WIDTH-1:0]  buf_mem [DEPTH];

  logic              xfer;
  logic              keep;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;

`ifdef STREAM_DEDUP_SORT_CHECK_EN
  logic              sort_err_q, sort_err_d;
`endif

  assign xfer    = in_if.in_valid && (state_q == S_RUN);
  assign wr_addr = k_q[AW-1:0];

  // run_cnt of zero marks "no element seen yet this pass"; it is >= 1 after any transfer.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    run_cnt_d  = run_cnt_q;
    prev_d     = prev_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    keep       = 1'b0;
    wr_en      = 1'b0;
`ifdef STREAM_DEDUP_SORT_CHECK_EN
    sort_err_d = sort_err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          k_d        = '0;
          run_cnt_d  = '0;
          overflow_d = 1'b0;
`ifdef STREAM_DEDUP_SORT_CHECK_EN
          sort_err_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (xfer) begin
          if ((run_cnt_q == '0) || (in_if.in_data != prev_q)) begin
            keep      = 1'b1;
            prev_d    = in_if.in_data;
            run_cnt_d = CW'(1);
          end else begin
            keep = (run_cnt_q < MAX_DUP_C);
            if (keep) run_cnt_d = run_cnt_q + CW'(1);
          end
          // A kept element that finds the buffer full is dropped, but still drives dedup state.
          if (keep) begin
            if (k_q < DEPTH_C) begin
              wr_en = 1'b1;
              k_d   = k_q + KW'(1);
            end else begin
              overflow_d = 1'b1;
            end
          end
`ifdef STREAM_DEDUP_SORT_CHECK_EN
          if ((run_cnt_q != '0) && (in_if.in_data < prev_q)) sort_err_d = 1'b1;
`endif
          if (in_if.in_last) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      run_cnt_q  <= '0;
      prev_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      run_cnt_q  <= run_cnt_d;
      prev_q     <= prev_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef STREAM_DEDUP_SORT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sort_err_q <= 1'b0;
    else     sort_err_q <= sort_err_d;
  end
  assign sort_err = sort_err_q;
`else
  assign sort_err = 1'b0;
`endif

  // Buffer storage is deliberately not reset; entries at index >= k are stale.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[wr_addr] <= in_if.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= buf_mem[rd_addr];
  end

  assign in_if.in_ready = (state_q == S_RUN);
  assign busy           = (state_q == S_RUN);
  assign done           = done_q;
  assign k              = k_q;
  assign overflow       = overflow_q;
  assign rd_data        = rd_data_q;

endmodule

// File: tb/tb_stream_dedup_buffer.sv
// Scoreboard bench for stream_dedup_buffer: instance A (DEPTH=4, MAX_DUP=1) and
// instance B (DEPTH=8, MAX_DUP=2) driven with directed streams.
module tb_stream_dedup_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam bit SERR_EN =
`ifdef STREAM_DEDUP_SORT_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct { int k; bit ovf; bit serr; } res_t;
  res_t qa[$];
  res_t qb[$];
  logic [31:0] rqa[$];
  logic [31:0] rqb[$];

  logic        vld [2];
  logic        lst [2];
  logic [31:0] dat [2];
  logic        rd_req  [2];
  logic        rd_pend [2];

  stream_dedup_buffer_if #(.WIDTH(32)) ia ();
  stream_dedup_buffer_if #(.WIDTH(32)) ib ();
  assign ia.in_valid = vld[0];
  assign ia.in_last  = lst[0];
  assign ia.in_data  = dat[0];
  assign ib.in_valid = vld[1];
  assign ib.in_last  = lst[1];
  assign ib.in_data  = dat[1];

  logic        start_a = 1'b0, busy_a, done_a, ovf_a, serr_a;
  logic [2:0]  k_a;
  logic [1:0]  rd_addr_a = '0;
  logic [31:0] rd_data_a;
  logic        start_b = 1'b0, busy_b, done_b, ovf_b, serr_b;
  logic [3:0]  k_b;
  logic [2:0]  rd_addr_b = '0;
  logic [31:0] rd_data_b;

  stream_dedup_buffer #(.WIDTH(32), .DEPTH(4), .MAX_DUP(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_if(ia), .busy(busy_a), .done(done_a),
    .k(k_a), .overflow(ovf_a), .sort_err(serr_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a));

  stream_dedup_buffer #(.WIDTH(32), .DEPTH(8), .MAX_DUP(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_if(ib), .busy(busy_b), .done(done_b),
    .k(k_b), .overflow(ovf_b), .sort_err(serr_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b));

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    rd_pend[0] <= rd_req[0];
    rd_pend[1] <= rd_req[1];
  end

  // Monitors: a done pulse pops a pass result, a pending read pops a buffer word.
  always @(negedge clk) begin : mon_a
    res_t r;
    if (done_a === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_unexpected_done: got done=1, required no done");
      end else begin
        r = qa.pop_front();
        chk("a_k", 64'(k_a), 64'(r.k));
        chk("a_overflow", 64'(ovf_a), 64'(r.ovf));
        chk("a_sort_err", 64'(serr_a), 64'(r.serr));
      end
    end
    if (rd_pend[0] === 1'b1) begin
      if (rqa.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL a_rd_orphan: got read with no expected value, required none");
      end else chk("a_rd_data", 64'(rd_data_a), 64'(rqa.pop_front()));
    end
  end

  always @(negedge clk) begin : mon_b
    res_t r;
    if (done_b === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_unexpected_done: got done=1, required no done");
      end else begin
        r = qb.pop_front();
        chk("b_k", 64'(k_b), 64'(r.k));
        chk("b_overflow", 64'(ovf_b), 64'(r.ovf));
        chk("b_sort_err", 64'(serr_b), 64'(r.serr));
      end
    end
    if (rd_pend[1] === 1'b1) begin
      if (rqb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_rd_orphan: got read with no expected value, required none");
      end else chk("b_rd_data", 64'(rd_data_b), 64'(rqb.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int sel);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic expect_pass(input int sel, input int kk, input bit ovf, input bit serr);
    res_t r;
    r.k = kk; r.ovf = ovf; r.serr = serr;
    if (sel == 0) qa.push_back(r); else qb.push_back(r);
  endtask

  task automatic send(input int sel, input logic [31:0] d, input logic last, input int gap);
    logic rdy;
    int   cnt;
    for (int i = 0; i < gap; i++) tick();
    vld[sel] = 1'b1; dat[sel] = d; lst[sel] = last;
    cnt = 0;
    do begin
      @(negedge clk);
      rdy = (sel == 0) ? ia.in_ready : ib.in_ready;
      tick();
      cnt++;
    end while (rdy !== 1'b1 && cnt < 20);
    vld[sel] = 1'b0; lst[sel] = 1'b0;
    if (rdy !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed low for %0d cycles, required 1", cnt);
    end
  endtask

  task automatic send_stream(input int sel, input int v[$], input bit last_on_end, input bit gaps);
    for (int i = 0; i < v.size(); i++)
      send(sel, 32'(v[i]), last_on_end && (i == v.size() - 1), gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic post_done(input int sel);
    @(negedge clk);
    if (sel == 0) begin
      chk("a_done_pulse", 64'(done_a), 64'd1);
      chk("a_in_ready_done", 64'(ia.in_ready), 64'd0);
      chk("a_busy_done", 64'(busy_a), 64'd0);
    end else begin
      chk("b_done_pulse", 64'(done_b), 64'd1);
      chk("b_in_ready_done", 64'(ib.in_ready), 64'd0);
      chk("b_busy_done", 64'(busy_b), 64'd0);
    end
    tick();
  endtask

  task automatic read_chk(input int sel, input int addr, input logic [31:0] exp);
    if (sel == 0) begin rd_addr_a = addr[1:0]; rqa.push_back(exp); end
    else          begin rd_addr_b = addr[2:0]; rqb.push_back(exp); end
    rd_req[sel] = 1'b1;
    tick();
    rd_req[sel] = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("a_rst_k", 64'(k_a), 64'd0);
    chk("a_rst_busy", 64'(busy_a), 64'd0);
    chk("a_rst_in_ready", 64'(ia.in_ready), 64'd0);
    chk("a_rst_done", 64'(done_a), 64'd0);
    chk("a_rst_overflow", 64'(ovf_a), 64'd0);
    chk("a_rst_sort_err", 64'(serr_a), 64'd0);
    chk("a_rst_rd_data", 64'(rd_data_a), 64'd0);
    chk("b_rst_k", 64'(k_b), 64'd0);
    chk("b_rst_in_ready", 64'(ib.in_ready), 64'd0);
    chk("b_rst_rd_data", 64'(rd_data_b), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s[$];
    int e[$];
    vld = '{1'b0, 1'b0}; lst = '{1'b0, 1'b0}; dat = '{32'd0, 32'd0};
    rd_req = '{1'b0, 1'b0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    tick();

    // A: remove all duplicates, stream fills the 4-entry buffer exactly
    pulse_start(0);
    s = '{1, 1, 2, 3, 3, 3, 4};
    expect_pass(0, 4, 1'b0, 1'b0);
    send_stream(0, s, 1'b1, 1'b0);
    post_done(0);
    for (int i = 0; i < 4; i++) read_chk(0, i, 32'(i + 1));

    // A: overflow, then a new start clears k and overflow
    pulse_start(0);
    s = '{1, 2, 3, 4, 5, 6};
    expect_pass(0, 4, 1'b1, 1'b0);
    send_stream(0, s, 1'b1, 1'b0);
    post_done(0);
    for (int i = 0; i < 4; i++) read_chk(0, i, 32'(i + 1));
    pulse_start(0);
    @(negedge clk);
    chk("a_restart_k", 64'(k_a), 64'd0);
    chk("a_restart_overflow", 64'(ovf_a), 64'd0);
    chk("a_restart_in_ready", 64'(ia.in_ready), 64'd1);
    chk("a_restart_busy", 64'(busy_a), 64'd1);
    tick();
    s = '{9};
    expect_pass(0, 1, 1'b0, 1'b0);
    send_stream(0, s, 1'b1, 1'b0);
    post_done(0);
    read_chk(0, 0, 32'd9);

    // A: random valid gaps with a start pulse mid-pass that must be ignored
    pulse_start(0);
    expect_pass(0, 4, 1'b0, 1'b0);
    s = '{1, 1, 2};
    send_stream(0, s, 1'b0, 1'b1);
    pulse_start(0);
    s = '{3, 3, 3, 4};
    send_stream(0, s, 1'b1, 1'b1);
    post_done(0);
    for (int i = 0; i < 4; i++) read_chk(0, i, 32'(i + 1));

    // A: reset mid-pass discards it, then a fresh pass
    pulse_start(0);
    s = '{1, 2, 3};
    send_stream(0, s, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    tick();
    pulse_start(0);
    s = '{7, 7, 8};
    expect_pass(0, 2, 1'b0, 1'b0);
    send_stream(0, s, 1'b1, 1'b0);
    post_done(0);
    read_chk(0, 1, 32'd8);
    read_chk(0, 0, 32'd7);

    // A: descending step handled as a new value; sort_err only with the checker built in
    pulse_start(0);
    s = '{5, 3, 3};
    expect_pass(0, 2, 1'b0, SERR_EN);
    send_stream(0, s, 1'b1, 1'b0);
    post_done(0);
    read_chk(0, 0, 32'd5);
    read_chk(0, 1, 32'd3);
    chk("a_sort_err_held", 64'(serr_a), 64'(SERR_EN));
    pulse_start(0);
    @(negedge clk);
    chk("a_sort_err_cleared", 64'(serr_a), 64'd0);
    tick();
    s = '{1};
    expect_pass(0, 1, 1'b0, 1'b0);
    send_stream(0, s, 1'b1, 1'b0);
    post_done(0);

    // B: keep at most two copies
    pulse_start(1);
    s = '{0, 0, 0, 1, 1, 1, 2, 3, 3};
    expect_pass(1, 7, 1'b0, 1'b0);
    send_stream(1, s, 1'b1, 1'b0);
    post_done(1);
    e = '{0, 0, 1, 1, 2, 3, 3};
    for (int i = 0; i < 7; i++) read_chk(1, i, 32'(e[i]));

    // B: fills all 8 entries, last kept value overflows
    pulse_start(1);
    s = '{1, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    expect_pass(1, 8, 1'b1, 1'b0);
    send_stream(1, s, 1'b1, 1'b0);
    post_done(1);
    e = '{1, 1, 2, 2, 3, 3, 4, 4};
    for (int i = 0; i < 8; i++) read_chk(1, i, 32'(e[i]));

    repeat (3) tick();
    chk("a_results_drained", 64'(qa.size()), 64'd0);
    chk("b_results_drained", 64'(qb.size()), 64'd0);
    chk("a_reads_drained", 64'(rqa.size()), 64'd0);
    chk("b_reads_drained", 64'(rqb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
